mm_nmac: RTL and testbench

Parametrised N×N signed matrix multiplier with LANES parallel multiply-accumulate lanes and a backpressured result stream. Successor to the fixed 8×8, two-MAC multiplier in the matrix-multiply datapath: operand matrices are loaded through a write port rather than preloaded from files, and results leave on a valid/ready stream instead of an unconditional RAM write. It sits between the operand loader and the result RAM/consumer.

---
 rtl/mm_pkg.sv | 22 ++
 rtl/mm_nmac_if.sv | 35 +++
 rtl/mm_mac_lane.sv | 36 +++
 rtl/mm_nmac.sv | 226 ++++++++++++++++++++++
 tb/tb_mm_nmac.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the N x N matrix multiplier slice.
//   mm_state_t : controller states
//   LD_A/LD_B  : ld_sel encodings for the operand write port
//   mm_aw()    : accumulator/result width that holds N * (-2^(DW-1))^2
package mm_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      WAIT,
      FLUSH,
      DONE
   } mm_state_t;

   localparam logic LD_A = 1'b0;
   localparam logic LD_B = 1'b1;

   function automatic int unsigned mm_aw(input int unsigned n, input int unsigned dw);
      return 2 * dw + $clog2(n);
   endfunction

endpackage

// File: rtl/mm_nmac_if.sv
// Result stream of the matrix multiplier (valid/ready handshake).
//   out_valid : result word available
//   out_ready : consumer accepts the word (transfer on valid && ready)
//   out_data  : signed C[out_row][out_col]
//   out_row   : result row index
//   out_col   : result column index
// master = producer (mm_nmac), slave = consumer.
interface mm_nmac_if #(
   parameter int unsigned N  = 8,
   parameter int unsigned AW = 19
);

   logic                    out_valid;
   logic                    out_ready;
   logic signed [AW-1:0]    out_data;
   logic [$clog2(N)-1:0]    out_row;
   logic [$clog2(N)-1:0]    out_col;

   modport master (
      output out_valid,
      output out_data,
      output out_row,
      output out_col,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_row,
      input  out_col,
      output out_ready
   );

endinterface

// File: rtl/mm_mac_lane.sv
// One signed multiply-accumulate lane.
//   clk, reset : clock, synchronous active-low reset (clears acc)
//   en         : perform this cycle's step
//   clr_load   : with en, the step is the last of a dot product: the
//                caller captures sum and the accumulator restarts at zero
//   a, b       : signed operands
//   acc        : running accumulator
//   sum        : acc + a*b (combinational)
module mm_mac_lane #(
   parameter int unsigned DW = 8,
   parameter int unsigned AW = 19
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 clr_load,
   input  logic signed [DW-1:0] a,
   input  logic signed [DW-1:0] b,
   output logic signed [AW-1:0] acc,
   output logic signed [AW-1:0] sum
);

   logic signed [2*DW-1:0] prod;

   assign prod = a * b;
   assign sum  = acc + AW'(prod);

   always_ff @(posedge clk) begin
      if (!reset) begin
         acc <= '0;
      end else if (en) begin
         acc <= clr_load ? '0 : sum;
      end
   end

endmodule

// File: rtl/mm_nmac.sv
// Parametrised N x N signed matrix multiplier with LANES parallel MAC lanes
// and a backpressured result stream.
//   clk, reset          : clock, synchronous active-low reset
//   start               : begin a multiply (accepted in IDLE or DONE)
//   ld_en/ld_sel        : operand write strobe, 0 = A, 1 = B (dropped while busy)
//   ld_addr/ld_data     : column-major operand address and signed value
//   busy                : RUN, WAIT or FLUSH
//   done                : DONE
//   clk_count           : busy cycles of the last or current run
//   res                 : result stream (out_valid/out_ready/out_data/out_row/out_col)
// Work order: column j, then row group g, then k. Lane l computes row
// g*LANES+l; all lanes share B[k][j].
module mm_nmac
   import mm_pkg::*;
#(
   parameter int unsigned N     = 8,
   parameter int unsigned DW    = 8,
   parameter int unsigned LANES = 2,
   parameter int unsigned AW    = mm_aw(N, DW)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      ld_en,
   input  logic                      ld_sel,
   input  logic [$clog2(N*N)-1:0]    ld_addr,
   input  logic signed [DW-1:0]      ld_data,
   output logic                      busy,
   output logic                      done,
   output logic [31:0]               clk_count,
   mm_nmac_if.master                 res
);

   localparam int unsigned IW = $clog2(N);
   localparam int unsigned AD = $clog2(N * N);
   localparam int unsigned NG = N / LANES;
   localparam int unsigned GW = (NG > 1) ? $clog2(NG) : 1;
   localparam int unsigned CW = $clog2(LANES + 1);

   mm_state_t state, state_next;

   logic [IW-1:0] k, j;
   logic [GW-1:0] g;

   logic signed [DW-1:0] mem_a [N*N];
   logic signed [DW-1:0] mem_b [N*N];

   logic signed [DW-1:0] lane_a   [LANES];
   logic signed [DW-1:0] b_cur;
   logic signed [AW-1:0] lane_acc [LANES];
   logic signed [AW-1:0] lane_sum [LANES];

   // Result buffer: entry 0 is the head; entries shift down on each transfer.
   logic signed [AW-1:0] buf_data [LANES];
   logic [IW-1:0]        buf_row  [LANES];
   logic [IW-1:0]        buf_col  [LANES];
   logic [CW-1:0]        buf_cnt;

   logic last_k, last_grp, xfer, buf_free, last_xfer;
   logic lane_en, lane_clr, buf_load, run_init;

   assign busy = (state == RUN) || (state == WAIT) || (state == FLUSH);
   assign done = (state == DONE);

   assign last_k    = (k == IW'(N - 1));
   assign last_grp  = (g == GW'(NG - 1)) && (j == IW'(N - 1));
   assign xfer      = res.out_valid && res.out_ready;
   // The buffer may be reloaded when empty, or when this cycle's transfer
   // takes its final entry.
   assign last_xfer = (buf_cnt == CW'(1)) && res.out_ready;
   assign buf_free  = (buf_cnt == '0) || last_xfer;

   assign res.out_valid = (buf_cnt != '0);
   assign res.out_data  = buf_data[0];
   assign res.out_row   = buf_row[0];
   assign res.out_col   = buf_col[0];

   // Operand storage: no reset, contents survive aborts.
   always_ff @(posedge clk) begin
      if (ld_en && !busy) begin
         if (ld_sel == LD_A) begin
            mem_a[ld_addr] <= ld_data;
         end else begin
            mem_b[ld_addr] <= ld_data;
         end
      end
   end

   // A[i][k] lives at k*N+i, B[k][j] at j*N+k.
   always_comb begin
      b_cur = mem_b[AD'(j * N + k)];
      for (int unsigned l = 0; l < LANES; l++) begin
         lane_a[l] = mem_a[AD'(k * N + g * LANES + l)];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A stalled k = N-1 step holds acc (lane_en low) and completes from WAIT.
   always_comb begin
      state_next = state;
      lane_en    = 1'b0;
      lane_clr   = 1'b0;
      buf_load   = 1'b0;
      run_init   = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_next = RUN;
               run_init   = 1'b1;
            end
         end
         RUN: begin
            if (!last_k) begin
               lane_en = 1'b1;
            end else if (buf_free) begin
               lane_en    = 1'b1;
               lane_clr   = 1'b1;
               buf_load   = 1'b1;
               state_next = last_grp ? FLUSH : RUN;
            end else begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (buf_free) begin
               lane_en    = 1'b1;
               lane_clr   = 1'b1;
               buf_load   = 1'b1;
               state_next = last_grp ? FLUSH : RUN;
            end
         end
         FLUSH: begin
            if (last_xfer) begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset || run_init) begin
         k <= '0;
         g <= '0;
         j <= '0;
      end else if (buf_load) begin
         k <= '0;
         if (g == GW'(NG - 1)) begin
            g <= '0;
            j <= j + IW'(1);
         end else begin
            g <= g + GW'(1);
         end
      end else if (lane_en) begin
         k <= k + IW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset || run_init) begin
         clk_count <= '0;
      end else if (busy) begin
         clk_count <= clk_count + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         buf_cnt <= '0;
         for (int unsigned l = 0; l < LANES; l++) begin
            buf_data[l] <= '0;
            buf_row[l]  <= '0;
            buf_col[l]  <= '0;
         end
      end else if (buf_load) begin
         buf_cnt <= CW'(LANES);
         for (int unsigned l = 0; l < LANES; l++) begin
            buf_data[l] <= lane_sum[l];
            buf_row[l]  <= IW'(g * LANES + l);
            buf_col[l]  <= j;
         end
      end else if (xfer) begin
         buf_cnt <= buf_cnt - CW'(1);
         for (int unsigned l = 0; l + 1 < LANES; l++) begin
            buf_data[l] <= buf_data[l+1];
            buf_row[l]  <= buf_row[l+1];
            buf_col[l]  <= buf_col[l+1];
         end
         buf_data[LANES-1] <= '0;
         buf_row[LANES-1]  <= '0;
         buf_col[LANES-1]  <= '0;
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      mm_mac_lane #(
         .DW(DW),
         .AW(AW)
      ) u_lane (
         .clk      (clk),
         .reset    (reset),
         .en       (lane_en),
         .clr_load (lane_clr),
         .a        (lane_a[l]),
         .b        (b_cur),
         .acc      (lane_acc[l]),
         .sum      (lane_sum[l])
      );

      // Every group ends by clearing its accumulator, so outside a run
      // the lanes must sit at zero.
      always_ff @(posedge clk) begin
         if (reset && (state == IDLE || state == DONE)) begin
            assert (lane_acc[l] == '0);
         end
      end
   end

endmodule

// File: tb/tb_mm_nmac.sv
module tb_mm_nmac;
   import mm_pkg::*;

   typedef struct {
      int data;
      int row;
      int col;
   } res_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   logic              start_s   [3];
   logic              ld_en_s   [3];
   logic              ld_sel_s  [3];
   logic [5:0]        ld_addr_s [3];
   logic signed [7:0] ld_data_s [3];
   logic              ready_s   [3];

   logic               busy_s  [3];
   logic               done_s  [3];
   logic               valid_s [3];
   logic [31:0]        cnt_s   [3];
   logic signed [18:0] data_s  [3];
   logic [2:0]         row_s   [3];
   logic [2:0]         col_s   [3];

   int   ma [8][8];
   int   mb [8][8];
   res_t exp_q [$];
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   mm_nmac_if #(.N(8), .AW(19)) if0 ();
   mm_nmac_if #(.N(8), .AW(19)) if1 ();
   mm_nmac_if #(.N(4), .AW(18)) if2 ();

   assign if0.out_ready = ready_s[0];
   assign if1.out_ready = ready_s[1];
   assign if2.out_ready = ready_s[2];
   assign valid_s[0] = if0.out_valid;
   assign valid_s[1] = if1.out_valid;
   assign valid_s[2] = if2.out_valid;
   assign data_s[0]  = if0.out_data;
   assign data_s[1]  = if1.out_data;
   assign data_s[2]  = 19'(if2.out_data);
   assign row_s[0]   = if0.out_row;
   assign row_s[1]   = if1.out_row;
   assign row_s[2]   = {1'b0, if2.out_row};
   assign col_s[0]   = if0.out_col;
   assign col_s[1]   = if1.out_col;
   assign col_s[2]   = {1'b0, if2.out_col};

   mm_nmac #(.N(8), .DW(8), .LANES(2)) u_dut0 (
      .clk(clk), .reset(reset), .start(start_s[0]), .ld_en(ld_en_s[0]),
      .ld_sel(ld_sel_s[0]), .ld_addr(ld_addr_s[0]), .ld_data(ld_data_s[0]),
      .busy(busy_s[0]), .done(done_s[0]), .clk_count(cnt_s[0]), .res(if0)
   );

   mm_nmac #(.N(8), .DW(8), .LANES(4)) u_dut1 (
      .clk(clk), .reset(reset), .start(start_s[1]), .ld_en(ld_en_s[1]),
      .ld_sel(ld_sel_s[1]), .ld_addr(ld_addr_s[1]), .ld_data(ld_data_s[1]),
      .busy(busy_s[1]), .done(done_s[1]), .clk_count(cnt_s[1]), .res(if1)
   );

   mm_nmac #(.N(4), .DW(8), .LANES(1)) u_dut2 (
      .clk(clk), .reset(reset), .start(start_s[2]), .ld_en(ld_en_s[2]),
      .ld_sel(ld_sel_s[2]), .ld_addr(ld_addr_s[2][3:0]), .ld_data(ld_data_s[2]),
      .busy(busy_s[2]), .done(done_s[2]), .clk_count(cnt_s[2]), .res(if2)
   );

   function automatic int dim(input int d);
      return (d == 2) ? 4 : 8;
   endfunction

   function automatic int lanes(input int d);
      return (d == 0) ? 2 : (d == 1) ? 4 : 1;
   endfunction

   task automatic check(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Consumer readiness in run cycle m (cycle m ends at the m-th edge after start).
   function automatic bit ready_at(input int m, input int lo, input int len);
      return !(len != 0 && m >= lo && m < lo + len);
   endfunction

   // Edge at which a buffer loaded at edge t0 has handed over all its entries.
   function automatic int drain_edge(input int t0, input int l, input int lo, input int len);
      int c, got;
      c = t0;
      got = 0;
      while (got < l) begin
         c++;
         if (ready_at(c, lo, len)) got++;
      end
      return c;
   endfunction

   // Each group needs N compute cycles and may only deliver once the previous
   // group's results are gone; the run ends when the last group has drained.
   function automatic int model_cnt(input int n, input int l, input int lo, input int len);
      int load, t;
      load = n;
      for (int grp = 1; grp < n * n / l; grp++) begin
         t = drain_edge(load, l, lo, len);
         load = (load + n > t) ? load + n : t;
      end
      return drain_edge(load, l, lo, len);
   endfunction

   task automatic build_expect(input int n);
      res_t r;
      exp_q.delete();
      for (int j = 0; j < n; j++) begin
         for (int i = 0; i < n; i++) begin
            r.data = 0;
            for (int k = 0; k < n; k++) r.data += ma[i][k] * mb[k][j];
            r.row = i;
            r.col = j;
            exp_q.push_back(r);
         end
      end
   endtask

   task automatic check_idle(input int d, input string tag);
      check({tag, "_busy"},  busy_s[d],  0);
      check({tag, "_done"},  done_s[d],  0);
      check({tag, "_valid"}, valid_s[d], 0);
      check({tag, "_count"}, cnt_s[d],   0);
      check({tag, "_data"},  data_s[d],  0);
      check({tag, "_row"},   row_s[d],   0);
      check({tag, "_col"},   col_s[d],   0);
   endtask

   // Writes A then B; optionally raises start together with the final write.
   task automatic load_ops(input int d, input bit with_start);
      int n, total, w;
      n = dim(d);
      total = 2 * n * n;
      w = 0;
      for (int sel = 0; sel < 2; sel++) begin
         for (int x = 0; x < n; x++) begin
            for (int y = 0; y < n; y++) begin
               @(negedge clk);
               w++;
               ld_en_s[d]  = 1'b1;
               ld_sel_s[d] = (sel == 0) ? LD_A : LD_B;
               if (sel == 0) begin
                  ld_addr_s[d] = 6'(y * n + x);
                  ld_data_s[d] = 8'(ma[x][y]);
               end else begin
                  ld_addr_s[d] = 6'(x * n + y);
                  ld_data_s[d] = 8'(mb[y][x]);
               end
               start_s[d] = with_start && (w == total);
               @(posedge clk);
            end
         end
      end
   endtask

   task automatic run_dut(input int d, input bit pre, input int lo, input int len,
                          input int rst_at, input int ld_at);
      int  n, l;
      bit  seen, fin, stalled, rdy;
      n = dim(d);
      l = lanes(d);
      seen = 0;
      fin = 0;
      stalled = 0;
      build_expect(n);
      @(negedge clk);
      ld_en_s[d] = 1'b0;
      if (!pre) begin
         start_s[d] = 1'b1;
         @(posedge clk);
         @(negedge clk);
      end
      start_s[d] = 1'b0;
      for (int m = 1; m <= 2000 && !fin; m++) begin
         if (rst_at != 0 && m == rst_at) begin
            reset = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check_idle(d, "abort");
            reset = 1'b1;
            exp_q.delete();
            return;
         end
         rdy = ready_at(m, lo, len);
         if (valid_s[d]) begin
            if (!seen) begin
               seen = 1;
               check("first_valid_cycle", m, n + 1);
            end
            if (exp_q.size() == 0) begin
               check("extra_output", 1, 0);
            end else begin
               check($sformatf("d%0d_data_r%0d_c%0d", d, exp_q[0].row, exp_q[0].col),
                     data_s[d], exp_q[0].data);
               check("out_row", row_s[d], exp_q[0].row);
               check("out_col", col_s[d], exp_q[0].col);
               if (rdy) void'(exp_q.pop_front());
            end
         end else if (stalled) begin
            check("valid_held", 0, 1);
         end
         stalled = valid_s[d] && !rdy;
         if (done_s[d]) begin
            check("clk_count_model", cnt_s[d], model_cnt(n, l, lo, len));
            check("results_left", exp_q.size(), 0);
            check("busy_at_done", busy_s[d], 0);
            fin = 1;
         end else begin
            ready_s[d]   = rdy;
            ld_en_s[d]   = (m == ld_at);
            ld_sel_s[d]  = LD_A;
            ld_addr_s[d] = '0;
            ld_data_s[d] = 8'sd127;
            @(posedge clk);
            @(negedge clk);
         end
      end
      if (!fin) check("run_timeout", 0, 1);
      ready_s[d] = 1'b1;
      ld_en_s[d] = 1'b0;
   endtask

   task automatic fill_random(input int n);
      for (int x = 0; x < n; x++) begin
         for (int y = 0; y < n; y++) begin
            ma[x][y] = int'($urandom_range(255)) - 128;
            mb[x][y] = int'($urandom_range(255)) - 128;
         end
      end
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         start_s[d]   = 1'b0;
         ld_en_s[d]   = 1'b0;
         ld_sel_s[d]  = LD_A;
         ld_addr_s[d] = '0;
         ld_data_s[d] = '0;
         ready_s[d]   = 1'b1;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle(0, "rst0");
      check_idle(1, "rst1");
      check_idle(2, "rst2");
      reset = 1'b1;

      // Identity x ramp: C equals B.
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < 8; k++) begin
            ma[i][k] = (i == k) ? 1 : 0;
            mb[i][k] = 8 * i + k - 32;
         end
      end
      load_ops(0, 0);
      run_dut(0, 0, 0, 0, 0, 0);
      check("clk_count_258", cnt_s[0], 258);
      check("done_held", done_s[0], 1);

      // Most negative operands everywhere: 8 * 16384 = 131072.
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < 8; k++) begin
            ma[i][k] = -128;
            mb[i][k] = -128;
         end
      end
      load_ops(0, 0);
      run_dut(0, 0, 0, 0, 0, 0);

      // Random operands with a 20-cycle consumer stall from cycle 30.
      fill_random(8);
      load_ops(0, 0);
      run_dut(0, 0, 30, 20, 0, 0);

      // Abort at cycle 100, then rerun from retained operands with a
      // dropped write to A[0][0] during the run.
      run_dut(0, 0, 0, 0, 100, 0);
      run_dut(0, 0, 0, 0, 0, 20);

      // Four lanes, identity x identity, start together with the last write.
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < 8; k++) begin
            ma[i][k] = (i == k) ? 1 : 0;
            mb[i][k] = (i == k) ? 1 : 0;
         end
      end
      load_ops(1, 1);
      run_dut(1, 1, 0, 0, 0, 0);
      check("clk_count_132", cnt_s[1], 132);

      // N=4, one lane, random operands with stalls.
      fill_random(4);
      load_ops(2, 0);
      run_dut(2, 0, 6, 9, 0, 0);
      fill_random(4);
      load_ops(2, 0);
      run_dut(2, 0, 2, 30, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
